// File: rtl/gate_arb_pkg.sv
// Shared constants for the gate operation arbiter: opcode values and FSM state encodings.
package gate_arb_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gate_unit.sv
// Shared W-bit bitwise logic unit (AND / OR / NOT a); purely combinational.
module gate_unit
  import gate_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         rsv
);

  always_comb begin
    y   = '0;
    rsv = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      default: rsv = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one gate_unit among NREQ requesters (IDLE -> EXEC -> DONE).
// Define GATE_ARB_ERR_EN to report reserved opcodes on err during the DONE cycle.
module gate_op_arbiter
  import gate_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  localparam int RW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] a,
  input  logic [W*NREQ-1:0] b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic [RW-1:0]     rid,
  output logic              err
);

  logic [1:0]      state_reg;
  logic [RW-1:0]   ptr_reg;
  logic [RW-1:0]   sel_reg;
  logic [RW-1:0]   rid_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] done_reg;
  logic [W-1:0]    result_reg;
  logic [1:0]      op_lat_reg;
  logic [W-1:0]    a_lat_reg;
  logic [W-1:0]    b_lat_reg;

  logic [1:0]      op_arr [NREQ];
  logic [W-1:0]    a_arr  [NREQ];
  logic [W-1:0]    b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
    assign op_arr[gi] = op[2*gi +: 2];
    assign a_arr[gi]  = a[W*gi +: W];
    assign b_arr[gi]  = b[W*gi +: W];
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  logic [RW-1:0] pick_idx;
  logic          found;
  int            scan;
  logic [RW-1:0] scan_idx;

  always_comb begin
    pick_idx = '0;
    found    = 1'b0;
    scan     = 0;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan = int'(ptr_reg) + i;
      if (scan >= NREQ) scan = scan - NREQ;
      scan_idx = RW'(scan);
      if (req[scan_idx]) begin
        pick_idx = scan_idx;
        found    = 1'b1;
      end
    end
  end

  logic [W-1:0] gate_y;
  logic         gate_rsv;

  gate_unit #(.W(W)) u_gate (
    .op  (op_lat_reg),
    .a   (a_lat_reg),
    .b   (b_lat_reg),
    .y   (gate_y),
    .rsv (gate_rsv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      sel_reg    <= '0;
      rid_reg    <= '0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      result_reg <= '0;
      op_lat_reg <= '0;
      a_lat_reg  <= '0;
      b_lat_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (found) begin
            op_lat_reg <= op_arr[pick_idx];
            a_lat_reg  <= a_arr[pick_idx];
            b_lat_reg  <= b_arr[pick_idx];
            sel_reg    <= pick_idx;
            gnt_reg    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            state_reg  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_reg <= gate_rsv ? '0 : gate_y;
          rid_reg    <= sel_reg;
          done_reg   <= gnt_reg;
          state_reg  <= ST_DONE;
        end
        ST_DONE: begin
          done_reg  <= '0;
          gnt_reg   <= '0;
          ptr_reg   <= (rid_reg == RW'(NREQ - 1)) ? '0 : rid_reg + 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_ARB_ERR_EN
  logic err_reg;

  // Only the EXEC->DONE edge can raise err, so it is high for the DONE cycle alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else        err_reg <= (state_reg == ST_EXEC) && gate_rsv;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign rid    = rid_reg;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed bench for gate_op_arbiter (NREQ=4, W=8) with hand-computed expected values.
module tb_gate_op_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  result;
  logic [1:0]  rid;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

`ifdef GATE_ARB_ERR_EN
  localparam logic RSV_ERR = 1'b1;
`else
  localparam logic RSV_ERR = 1'b0;
`endif

  gate_op_arbiter #(.NREQ(4), .W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .op     (op),
    .a      (a),
    .b      (b),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .rid    (rid),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv);
    op[2*i +: 2] = o;
    a[8*i +: 8]  = av;
    b[8*i +: 8]  = bv;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // drop: 0 keep req, 1 drop req and scramble operands right after gnt, 2 drop req after done.
  task automatic run_op(input string tag, input int k, input logic [7:0] res,
                        input logic e, input int drop);
    int waited;
    logic [3:0] onehot;
    onehot = 4'b0001 << k;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (gnt == 4'b0000 && waited < 8);
    if (gnt == 4'b0000) begin
      check_val({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check_val({tag, " lat"}, waited, 1);
    check_val({tag, " gnt"}, gnt, onehot);
    check_val({tag, " early_done"}, done, 4'b0000);
    if (drop == 1) begin
      req = 4'b0000;
      a[8*k +: 8] = ~a[8*k +: 8];
      b[8*k +: 8] = ~b[8*k +: 8];
    end
    @(posedge clk);
    #1;
    check_val({tag, " done"}, done, onehot);
    check_val({tag, " gnt_hold"}, gnt, onehot);
    check_val({tag, " result"}, result, res);
    check_val({tag, " rid"}, rid, k);
    check_val({tag, " err"}, err, e);
    $display("op %-10s rid=%0d result=%02h err=%0b", tag, rid, result, err);
    if (drop == 2) req = 4'b0000;
    @(posedge clk);
    #1;
    check_val({tag, " done_fall"}, done, 4'b0000);
    check_val({tag, " gnt_fall"}, gnt, 4'b0000);
    check_val({tag, " err_fall"}, err, 1'b0);
  endtask

  initial begin
    req = '0;
    op  = '0;
    a   = '0;
    b   = '0;
    do_reset();
    check_val("rst gnt", gnt, 4'b0000);
    check_val("rst done", done, 4'b0000);
    check_val("rst result", result, 8'h00);
    check_val("rst rid", rid, 2'd0);
    check_val("rst err", err, 1'b0);

    // ptr 0: AND on requester 0
    set_req(0, 2'b00, 8'hF0, 8'h3C);
    req = 4'b0001;
    run_op("and0", 0, 8'h30, 1'b0, 2);

    // ptr 1: OR on requester 2
    set_req(2, 2'b01, 8'hA0, 8'h05);
    req = 4'b0100;
    run_op("or2", 2, 8'hA5, 1'b0, 2);

    // ptr 3: NOT on requester 1, b must not matter
    set_req(1, 2'b10, 8'h0F, 8'h55);
    req = 4'b0010;
    run_op("not1", 1, 8'hF0, 1'b0, 2);

    // ptr 2: reset in the middle of serving requester 2
    req = 4'b0100;
    @(posedge clk);
    #1;
    check_val("rstmid gnt", gnt, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid gnt0", gnt, 4'b0000);
    check_val("rstmid done0", done, 4'b0000);
    check_val("rstmid result0", result, 8'h00);
    check_val("rstmid rid0", rid, 2'd0);
    check_val("rstmid err0", err, 1'b0);
    req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_val("rstmid no_done", done, 4'b0000);
    end
    // ptr back at 0 -> requester 1 beats requester 2
    req = 4'b0110;
    run_op("rst_ptr", 1, 8'hF0, 1'b0, 2);

    // round robin from a fresh reset
    do_reset();
    set_req(3, 2'b00, 8'hFF, 8'h81);
    req = 4'b1111;
    run_op("rr0", 0, 8'h30, 1'b0, 0);
    run_op("rr1", 1, 8'hF0, 1'b0, 0);
    run_op("rr2", 2, 8'hA5, 1'b0, 0);
    run_op("rr3", 3, 8'h81, 1'b0, 0);
    run_op("rr0b", 0, 8'h30, 1'b0, 2);

    // ptr 1: requester 3 withdraws and its operands change during EXEC
    set_req(3, 2'b01, 8'h12, 8'h40);
    req = 4'b1000;
    run_op("withdraw3", 3, 8'h52, 1'b0, 1);

    // ptr 0: reserved opcode
    set_req(0, 2'b11, 8'hFF, 8'hFF);
    req = 4'b0001;
    run_op("rsv0", 0, 8'h00, RSV_ERR, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_op_arbiter.md
# gate_op_arbiter

Shares one W-bit logic unit (bitwise AND, OR, NOT) between NREQ requesters. A round-robin arbiter picks one requester at a time, latches its operands and opcode, and executes the operation. It then returns a registered result with a one-cycle done pulse addressed to the winner. It sits between the lab's stimulus and sequencer blocks and the shared gate datapath.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- W, default 8: operand and result width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  request per requester; held high until that requester's done pulse.
- op  in  2*NREQ  opcode per requester, slice [2i+1:2i]: 00 AND, 01 OR, 10 NOT a, 11 reserved.
- a  in  W*NREQ  operand a per requester, slice [W*i+W-1:W*i].
- b  in  W*NREQ  operand b per requester; ignored for NOT.
- gnt  out  NREQ  one-hot; high for the winner during EXEC and DONE.
- done  out  NREQ  one-hot, one-cycle pulse in DONE.
- result  out  W  result; valid while done is nonzero, held until the next DONE.
- rid  out  clog2(NREQ)  index of the served requester; valid with done.
- err  out  1  reserved-opcode flag; valid with done (see Configuration).

## Operation
- FSM states: IDLE, EXEC, DONE. Encodings come from the package.
- IDLE:
  - With no req, stay in IDLE.
  - Otherwise pick the first set req[k], searching k = ptr, ptr+1, … with wrap modulo NREQ.
  - Latch op[k], a[k] and b[k] into registers, set gnt[k], and go to EXEC.
- EXEC: the gate unit evaluates the latched operands. Register result, rid and err. Go to DONE.
- DONE:
  - Pulse done[rid] and set ptr = (rid+1) mod NREQ.
  - Clear gnt on the exit edge and go to IDLE.
- Fairness: the just-served requester has the lowest priority next round. Starvation bound is NREQ-1 operations.
- A requester dropping req during EXEC or DONE does not abort the operation; it completes and done still pulses.
- New or changing req, op, a or b during EXEC or DONE are ignored until the next IDLE.
- A requester that keeps req high after its done is re-arbitrated normally.
- NOT: result = ~a_latched, and b is ignored.
- All arithmetic is bitwise on W bits; there is no carry or extension.
- Reset values: state IDLE, ptr 0, gnt 0, done 0, result 0, rid 0, err 0, operand registers 0.
- Asynchronous reset mid-operation discards the in-flight operation: no done pulse and ptr returns to 0.

## Timing
- Arbitration samples req at the clock edge that leaves IDLE.
- With req[k] high at edge N (in IDLE):
  - gnt[k] is high from N+1.
  - done[k], result and rid are valid in cycle N+2 (after edge N+2).
  - gnt and done fall at N+3.
- Throughput: one operation every 3 cycles under continuous load.
- gnt, done, result, rid and err are driven directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- GATE_ARB_ERR_EN defined:
  - In EXEC, opcode 11 sets err=1 and forces result to 0.
  - err is valid only in the DONE cycle and 0 elsewhere.
- GATE_ARB_ERR_EN undefined:
  - Opcode 11 yields result 0.
  - err is tied 0.
  - The port remains for interface stability.

## Structure
- Package gate_arb_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_RSV=2'b11;
  - state encodings ST_IDLE, ST_EXEC, ST_DONE.
- Sub-module gate_unit: purely combinational, parameter W; inputs op, a, b; outputs y and rsv.
  - It is the only instance of the shared datapath.
- The round-robin search and the FSM stay in gate_op_arbiter.

## Test plan
- **Single AND:** reset, then req=4'b0001 with op0=00, a0=8'hF0, b0=8'h3C → gnt=0001 at N+1; done=0001, result=8'h30, rid=0 at N+2.
- **OR then NOT:**
  - req2 with op=01, a=8'hA0, b=8'h05 → result 8'hA5.
  - Then req1 with op=10, a=8'h0F → result 8'hF0, with b ignored.
- **Round robin:** req=4'b1111 held high → done order 0,1,2,3,0, each 3 cycles apart, with no done overlap.
- **Withdrawal:** drop req3 one cycle after gnt[3] rises → done[3] still pulses with a result computed from the latched operands.
- **Reset mid-op:** assert rst_n=0 during EXEC → all outputs 0 immediately and no done. After release, req=0010 is served first (ptr=0 search).
- **Reserved opcode:** op=11, a=8'hFF, b=8'hFF →
  - with GATE_ARB_ERR_EN: err=1, result=0;
  - without it: err=0, result=0.
